// File: rtl/sf_pkg.sv
// Shared sprite/animation definitions used by the player and effect sprite blocks.
package sf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2,
    PUNCH  = 2'd3
  } anim_state_t;

  localparam logic [1:0] FRAME_SEL_IDLE  = 2'd0;
  localparam logic [1:0] FRAME_SEL_WALK1 = 2'd1;
  localparam logic [1:0] FRAME_SEL_WALK2 = 2'd2;
  localparam logic [1:0] FRAME_SEL_PUNCH = 2'd3;

  localparam int SPRITE_DIM_DEFAULT = 128;
  localparam int SCREEN_W           = 640;
  localparam int SCREEN_H           = 480;

  // ROM bank select for each animation state
  function automatic logic [1:0] state_to_sel(input anim_state_t s);
    case (s)
      WALK_A:  state_to_sel = FRAME_SEL_WALK1;
      WALK_B:  state_to_sel = FRAME_SEL_WALK2;
      PUNCH:   state_to_sel = FRAME_SEL_PUNCH;
      default: state_to_sel = FRAME_SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite box test, horizontal mirroring and registered ROM address pipeline.
// rom_addr/sprite_active are one cycle after the scan position, pixel_valid two.
module sprite_addr_gen #(
  parameter int SPRITE_DIM = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [9:0]                        hcount,
  input  logic [9:0]                        vcount,
  input  logic [9:0]                        pos_x,
  input  logic [9:0]                        pos_y,
  input  logic                              facing_left,
  output logic [2*$clog2(SPRITE_DIM)-1:0]   rom_addr,
  output logic                              sprite_active,
  output logic                              pixel_valid
);

  localparam int         AW    = $clog2(SPRITE_DIM);
  localparam logic [10:0] DIM11 = 11'(SPRITE_DIM);

  logic [10:0]   w_dx, w_dy;
  logic          w_in_box;
  logic [AW-1:0] w_col, w_row;
  logic [2*AW-1:0] r_addr;
  logic          r_active, r_pix_vld;

  // 11-bit offsets: the explicit >= checks keep a negative offset from
  // looking like an in-range wrap, so a sprite near the right edge clips.
  assign w_dx     = {1'b0, hcount} - {1'b0, pos_x};
  assign w_dy     = {1'b0, vcount} - {1'b0, pos_y};
  assign w_in_box = (hcount >= pos_x) && (w_dx < DIM11) &&
                    (vcount >= pos_y) && (w_dy < DIM11);

  // DIM-1-dx equals bitwise inversion because DIM is a power of two
  assign w_col = facing_left ? ~w_dx[AW-1:0] : w_dx[AW-1:0];
  assign w_row = w_dy[AW-1:0];

  // Address/active register stage, then one more stage for the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_active  <= 1'b0;
      r_pix_vld <= 1'b0;
    end else begin
      r_active  <= w_in_box;
      r_pix_vld <= r_active;
      if (w_in_box) r_addr <= {w_row, w_col};
    end
  end

  assign rom_addr      = r_addr;
  assign sprite_active = r_active;
  assign pixel_valid   = r_pix_vld;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-player animation FSM: picks the sprite ROM once per video frame and
// drives the shared address generator for the scan position.
module sprite_anim_ctrl
  import sf_pkg::*;
#(
  parameter int SPRITE_DIM  = SPRITE_DIM_DEFAULT,
  parameter int WALK_TICKS  = 12,
  parameter int PUNCH_TICKS = 18
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic                            move_left,
  input  logic                            move_right,
  input  logic                            punch,
  input  logic                            facing_left,
  input  logic [9:0]                      pos_x,
  input  logic [9:0]                      pos_y,
  input  logic [9:0]                      hcount,
  input  logic [9:0]                      vcount,
  output logic [1:0]                      frame_sel,
  output logic [2*$clog2(SPRITE_DIM)-1:0] rom_addr,
  output logic                            sprite_active,
  output logic                            pixel_valid,
  output logic                            anim_busy
);

  localparam int CNT_MAX = (WALK_TICKS > PUNCH_TICKS) ? WALK_TICKS : PUNCH_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  anim_state_t r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [1:0]    r_frame_sel;

  // Next state/counter; only a frame_start pulse may move either
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (frame_start) begin
      if (r_state == PUNCH) begin
        // punch runs to completion, inputs ignored (no retrigger)
        if (r_cnt == CW'(PUNCH_TICKS - 1)) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end else if (punch) begin
        w_nxt_state = PUNCH;
        w_nxt_cnt   = '0;
      end else if (move_left ^ move_right) begin
        if (r_state == IDLE) begin
          w_nxt_state = WALK_A;
          w_nxt_cnt   = '0;
        end else if (r_cnt == CW'(WALK_TICKS - 1)) begin
          w_nxt_state = (r_state == WALK_A) ? WALK_B : WALK_A;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end else begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    end
  end

  // State, counter and registered ROM select (decoded from next state so it
  // lands on the same edge that samples frame_start)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame_sel <= FRAME_SEL_IDLE;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_frame_sel <= state_to_sel(w_nxt_state);
    end
  end

  assign frame_sel = r_frame_sel;
  assign anim_busy = (r_state == PUNCH);

  sprite_addr_gen #(.SPRITE_DIM(SPRITE_DIM)) u_addr (
    .clk           (clk),
    .rst_n         (rst_n),
    .hcount        (hcount),
    .vcount        (vcount),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .facing_left   (facing_left),
    .rom_addr      (rom_addr),
    .sprite_active (sprite_active),
    .pixel_valid   (pixel_valid)
  );

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl: address pipeline and animation FSM.
module tb_sprite_anim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, move_left, move_right, punch, facing_left;
  logic [9:0]  pos_x, pos_y, hcount, vcount;
  logic [1:0]  frame_sel;
  logic [13:0] rom_addr;
  logic        sprite_active, pixel_valid, anim_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        act;
    logic [13:0] addr;
  } pix_t;

  pix_t       q_pix[$];
  logic [1:0] q_sel[$];
  logic       prev_act;

  always #5 clk = ~clk;

  sprite_anim_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .move_left     (move_left),
    .move_right    (move_right),
    .punch         (punch),
    .facing_left   (facing_left),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .hcount        (hcount),
    .vcount        (vcount),
    .frame_sel     (frame_sel),
    .rom_addr      (rom_addr),
    .sprite_active (sprite_active),
    .pixel_valid   (pixel_valid),
    .anim_busy     (anim_busy)
  );

  // Present one scan position, then check the registered outputs it produced
  task automatic drive_pix(input int h, input int v, input int px, input int py, input bit fl);
    pix_t e;
    int   dx, dy;
    hcount = 10'(h); vcount = 10'(v); pos_x = 10'(px); pos_y = 10'(py); facing_left = fl;
    dx = h - px;
    dy = v - py;
    e.act  = (dx >= 0) && (dx < 128) && (dy >= 0) && (dy < 128);
    e.addr = e.act ? 14'(dy * 128 + (fl ? 127 - dx : dx)) : 14'd0;
    q_pix.push_back(e);
    @(posedge clk); #1;
    e = q_pix.pop_front();
    n_cmp++;
    if (sprite_active !== e.act) begin
      n_err++;
      $display("FAIL sprite_active h=%0d v=%0d: got %b want %b", h, v, sprite_active, e.act);
    end
    if (e.act) begin
      n_cmp++;
      if (rom_addr !== e.addr) begin
        n_err++;
        $display("FAIL rom_addr h=%0d v=%0d: got %0d want %0d", h, v, rom_addr, e.addr);
      end
    end
    n_cmp++;
    if (pixel_valid !== prev_act) begin
      n_err++;
      $display("FAIL pixel_valid h=%0d v=%0d: got %b want %b", h, v, pixel_valid, prev_act);
    end
    prev_act = e.act;
  endtask

  // One frame_start pulse, then a few mid-frame cycles with inputs wiggled
  task automatic frame_pulse(input logic [1:0] exp_sel, input string tag);
    logic [1:0] e;
    logic       sv_p, sv_l;
    q_sel.push_back(exp_sel);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    e = q_sel.pop_front();
    n_cmp++;
    if (frame_sel !== e) begin
      n_err++;
      $display("FAIL %s frame_sel: got %0d want %0d", tag, frame_sel, e);
    end
    n_cmp++;
    if (anim_busy !== (e == 2'd3)) begin
      n_err++;
      $display("FAIL %s anim_busy: got %b want %b", tag, anim_busy, (e == 2'd3));
    end
    sv_p = punch; sv_l = move_left;
    punch = ~punch; move_left = ~move_left;
    repeat (3) @(posedge clk);
    #1;
    punch = sv_p; move_left = sv_l;
    n_cmp++;
    if (frame_sel !== e) begin
      n_err++;
      $display("FAIL %s frame_sel mid-frame: got %0d want %0d", tag, frame_sel, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({frame_sel, rom_addr, sprite_active, pixel_valid, anim_busy} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: got sel=%0d addr=%0d act=%b pv=%b busy=%b want all 0",
               tag, frame_sel, rom_addr, sprite_active, pixel_valid, anim_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 0; move_left = 0; move_right = 0; punch = 0;
    facing_left = 0; pos_x = 10'd100; pos_y = 10'd200; hcount = 10'd1000; vcount = 10'd0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_act = 1'b0;
    @(posedge clk); #1;
    check_zero("after_reset");
  endtask

  task automatic test_addr();
    drive_pix(100, 200, 100, 200, 0);
    n_cmp++;
    if (rom_addr !== 14'd0) begin
      n_err++; $display("FAIL first_addr: got %0d want 0", rom_addr);
    end
    for (int h = 101; h <= 230; h++) drive_pix(h, 200, 100, 200, 0);
    drive_pix(99, 201, 100, 200, 0);
    drive_pix(150, 327, 100, 200, 0);
    drive_pix(150, 328, 100, 200, 0);
  endtask

  task automatic test_mirror();
    drive_pix(100, 200, 100, 200, 1);
    n_cmp++;
    if (rom_addr !== 14'd127) begin
      n_err++; $display("FAIL mirror_first: got %0d want 127", rom_addr);
    end
    drive_pix(227, 201, 100, 200, 1);
    n_cmp++;
    if (rom_addr !== 14'd128) begin
      n_err++; $display("FAIL mirror_row1: got %0d want 128", rom_addr);
    end
    for (int h = 90; h <= 240; h += 7) drive_pix(h, 260, 100, 200, 1);
  endtask

  task automatic test_clip();
    for (int h = 0; h < 640; h++) drive_pix(h, 250, 600, 200, 0);
  endtask

  task automatic test_walk();
    move_right = 1'b1;
    for (int p = 1; p <= 25; p++)
      frame_pulse((p < 13) ? 2'd1 : (p < 25) ? 2'd2 : 2'd1, "walk");
  endtask

  task automatic test_punch();
    // single-frame punch request during a walk
    punch = 1'b1;
    frame_pulse(2'd3, "punch_p1");
    punch = 1'b0;
    for (int p = 2; p <= 18; p++) frame_pulse(2'd3, "punch_run");
    frame_pulse(2'd0, "punch_end");
    frame_pulse(2'd1, "punch_walk_again");
    // punch held throughout: no retrigger inside the punch
    punch = 1'b1;
    for (int p = 1; p <= 18; p++) frame_pulse(2'd3, "punch_held");
    frame_pulse(2'd0, "punch_held_end");
    frame_pulse(2'd3, "punch_re_enter");
    punch = 1'b0; move_right = 1'b0;
    for (int p = 2; p <= 18; p++) frame_pulse(2'd3, "punch_run2");
    frame_pulse(2'd0, "punch_end2");
  endtask

  task automatic test_both();
    move_right = 1'b1;
    frame_pulse(2'd1, "both_pre_walk");
    move_left = 1'b1;
    frame_pulse(2'd0, "both_high");
    frame_pulse(2'd0, "both_high2");
    move_left = 1'b0; move_right = 1'b0;
    frame_pulse(2'd0, "neither");
  endtask

  task automatic test_reset_mid();
    drive_pix(150, 210, 100, 200, 0);
    drive_pix(150, 210, 100, 200, 0);
    punch = 1'b1;
    frame_pulse(2'd3, "mid_enter");
    punch = 1'b0;
    frame_pulse(2'd3, "mid_run");
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_punch");
    hcount = 10'd1000;
    prev_act = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    move_right = 1'b1;
    @(posedge clk); #1;
    frame_pulse(2'd1, "post_reset_walk");
  endtask

  initial begin
    test_reset();
    test_addr();
    test_mirror();
    test_clip();
    test_walk();
    test_punch();
    test_both();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
